// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable width, parity, stop bits and valid/ready output
module uart_rx_cfg #(
  parameter int CLOCK_FREQ = 38400000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 soft_reset,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);
  localparam int DIV = (CLOCK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DW = $clog2(DIV) < 1 ? 1 : $clog2(DIV);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);
  localparam logic [TW-1:0] T_LO = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_HI = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] S_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

  state_t                 state, state_n;
  logic                   rx_s1, rx_q;
  logic [DW-1:0]          div_cnt;
  logic [TW-1:0]          tick_idx;
  logic [1:0]             samp;
  logic [CW-1:0]          cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit, ferr, stop0;
  logic                   tick, vote_tick, bit_end, vote;
  logic                   complete, brk, par_x, pe, fe;

  assign tick      = div_cnt == DIV_M1;
  assign vote_tick = tick && tick_idx == T_HI;
  assign bit_end   = tick && tick_idx == T_END;
  assign vote      = (samp[0] & samp[1]) | (samp[0] & rx_q) | (samp[1] & rx_q);
  assign complete  = state == STOP && vote_tick && cnt == S_LAST;
  assign brk       = shreg == '0 && (PARITY == 0 || !par_bit) && (cnt == '0 ? !vote : stop0);
  assign par_x     = ^shreg ^ par_bit;
  assign pe        = PARITY == 1 ? !par_x : PARITY == 2 ? par_x : 1'b0;
  assign fe        = ferr | !vote;
  assign busy      = state != IDLE;

  // Two-flop synchroniser on the line, idling high
  always_ff @(posedge clk or posedge rst)
    if (rst) {rx_q, rx_s1} <= 2'b11;
    else {rx_q, rx_s1} <= soft_reset ? 2'b11 : {rx_s1, rx};

  // Tick divider and in-bit tick index, held at zero in IDLE so bit timing starts at the start edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div_cnt  <= '0;
      tick_idx <= '0;
    end else if (soft_reset || state == IDLE) begin
      div_cnt  <= '0;
      tick_idx <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      tick_idx <= tick_idx == T_END ? '0 : tick_idx + 1'b1;
    end else div_cnt <= div_cnt + 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= soft_reset ? IDLE : state_n;

  // Next-state logic; a frame completes at the last stop-bit vote, not at its bit end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = !rx_q ? START : IDLE;
      START:     state_n = vote_tick && vote ? IDLE : bit_end ? DATA : START;
      DATA:      state_n = bit_end && cnt == D_LAST ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:       state_n = bit_end ? STOP : PAR;
      STOP:      state_n = complete ? (brk ? WAIT_HIGH : IDLE) : STOP;
      WAIT_HIGH: state_n = rx_q ? IDLE : WAIT_HIGH;
      default:   state_n = IDLE;
    endcase
  end

  // Sample capture, bit counting, data shift and per-frame parity/stop bookkeeping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      samp    <= '0;
      cnt     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      ferr    <= 1'b0;
      stop0   <= 1'b0;
    end else begin
      if (tick && tick_idx == T_LO) samp[0] <= rx_q;
      if (tick && tick_idx == T_MID) samp[1] <= rx_q;
      cnt <= state != DATA && state != STOP ? '0 :
             bit_end ? (state == DATA && cnt == D_LAST ? '0 : cnt + 1'b1) : cnt;
      if (state == DATA && vote_tick) shreg <= {vote, shreg[DATA_BITS-1:1]};
      if (state == PAR && vote_tick) par_bit <= vote;
      if (state == START) ferr <= 1'b0;
      else if (state == STOP && vote_tick && !vote) ferr <= 1'b1;
      if (state == STOP && vote_tick && cnt == '0) stop0 <= !vote;
    end

  // Output word and flags on valid/ready; a completion while stalled is dropped and flagged as overrun
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid      <= 1'b0;
      data       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else if (soft_reset) begin
      valid      <= 1'b0;
      data       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      break_det <= complete && brk;
      if (complete && !brk && valid && !ready) overrun <= 1'b1;
      else if (complete && !brk) begin
        valid      <= 1'b1;
        data       <= shreg;
        parity_err <= pe;
        frame_err  <= fe;
      end else if (valid && ready) valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: randomized and directed checks of uart_rx_cfg against a frame-level reference model
module tb_uart_rx_cfg;
  localparam int CF = 768000;
  localparam int BIT = 80;

  logic clk = 1'b0, rst = 1'b1;
  logic rx0 = 1'b1, sr0 = 1'b0, rdy0 = 1'b0, v0, pe0, fe0, ov0, bk0, by0;
  logic [7:0] d0;
  logic rx1 = 1'b1, sr1 = 1'b0, rdy1 = 1'b0, v1, pe1, fe1, ov1, bk1, by1;
  logic [6:0] d1;
  int vectors = 0, miscompares = 0, brk0 = 0, brk1 = 0, vcyc0 = 0;
  logic [9:0] q0[$], q1[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLOCK_FREQ(CF)) u0 (
    .clk(clk), .rst(rst), .rx(rx0), .soft_reset(sr0), .data(d0), .valid(v0), .ready(rdy0),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .break_det(bk0), .busy(by0)
  );

  uart_rx_cfg #(.CLOCK_FREQ(CF), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .rx(rx1), .soft_reset(sr1), .data(d1), .valid(v1), .ready(rdy1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .break_det(bk1), .busy(by1)
  );

  // Record accepted words, break pulses and valid-high cycles at the falling edge
  always @(negedge clk) begin
    if (v0 && rdy0) q0.push_back({pe0, fe0, d0});
    if (v1 && rdy1) q1.push_back({pe1, fe1, 1'b0, d1});
    if (bk0) brk0++;
    if (bk1) brk1++;
    if (v0) vcyc0++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // 8N1 frame: expected {parity_err, frame_err, data}
  function automatic logic [9:0] m0(input logic [7:0] w, input logic s);
    return {1'b0, ~s, w};
  endfunction

  // 7E2 frame: even parity means data plus parity bit has an even number of ones
  function automatic logic [9:0] m1(input logic [6:0] w, input logic p, input logic s1, input logic s2);
    return {^w ^ p, ~(s1 & s2), 1'b0, w};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input int sel, input logic [15:0] bits, input int n);
    logic [16:0] f;
    f = {bits, 1'b0};
    step();
    for (int i = 0; i <= n; i++) begin
      if (sel == 0) rx0 = f[i]; else rx1 = f[i];
      repeat (BIT) step();
    end
    if (sel == 0) rx0 = 1'b1; else rx1 = 1'b1;
  endtask

  task automatic test_reset();
    idle(3);
    vectors++;
    if ({v0, pe0, fe0, ov0, bk0, by0, d0} !== 14'd0) begin
      miscompares++; $display("FAIL reset0_held got %h want 0", {v0, pe0, fe0, ov0, bk0, by0, d0});
    end
    rst = 1'b0;
    idle(3);
    vectors++;
    if ({v0, pe0, fe0, ov0, bk0, by0, d0} !== 14'd0) begin
      miscompares++; $display("FAIL reset0_after got %h want 0", {v0, pe0, fe0, ov0, bk0, by0, d0});
    end
    vectors++;
    if ({v1, pe1, fe1, ov1, bk1, by1, d1} !== 13'd0) begin
      miscompares++; $display("FAIL reset1_after got %h want 0", {v1, pe1, fe1, ov1, bk1, by1, d1});
    end
  endtask

  task automatic test_basic();
    int lat = 0, c;
    q0.delete(); rdy0 = 1'b1; c = vcyc0;
    fork
      send(0, {7'd0, 1'b1, 8'hA5}, 9);
      begin
        while (!v0 && lat < 1200) begin step(); lat++; end
      end
    join
    idle(2 * BIT);
    vectors++;
    if (lat < 740 || lat > 800) begin
      miscompares++; $display("FAIL basic_latency got %0d clk want 740..800", lat);
    end
    vectors++;
    if (vcyc0 - c !== 1) begin
      miscompares++; $display("FAIL basic_pulse got %0d cycles want 1", vcyc0 - c);
    end
    vectors++;
    if ((q0.size() > 0 ? q0[0] : 10'h3ff) !== m0(8'hA5, 1'b1) || q0.size() !== 1) begin
      miscompares++; $display("FAIL basic_word got %h (n=%0d) want %h", q0.size() > 0 ? q0[0] : 10'h3ff, q0.size(), m0(8'hA5, 1'b1));
    end
  endtask

  task automatic test_glitch();
    int c;
    q0.delete(); c = vcyc0;
    step(); rx0 = 1'b0;
    idle(10);
    vectors++;
    if (by0 !== 1'b1) begin miscompares++; $display("FAIL glitch_busy got %b want 1", by0); end
    idle(20); rx0 = 1'b1;
    idle(3 * BIT);
    vectors++;
    if (by0 !== 1'b0 || vcyc0 !== c) begin
      miscompares++; $display("FAIL glitch_idle got busy=%b valids=%0d want busy=0 valids=0", by0, vcyc0 - c);
    end
    send(0, {7'd0, 1'b1, 8'h3C}, 9);
    idle(2 * BIT);
    vectors++;
    if ((q0.size() > 0 ? q0[0] : 10'h3ff) !== m0(8'h3C, 1'b1) || q0.size() !== 1) begin
      miscompares++; $display("FAIL glitch_word got %h (n=%0d) want %h", q0.size() > 0 ? q0[0] : 10'h3ff, q0.size(), m0(8'h3C, 1'b1));
    end
  endtask

  task automatic test_parity();
    q1.delete(); rdy1 = 1'b1;
    send(1, {5'd0, 1'b1, 1'b1, 1'b1, 7'h55}, 10);
    idle(2 * BIT);
    send(1, {5'd0, 1'b1, 1'b1, 1'b0, 7'h55}, 10);
    idle(2 * BIT);
    vectors++;
    if (q1.size() !== 2) begin miscompares++; $display("FAIL parity_count got %0d want 2", q1.size()); end
    vectors++;
    if ((q1.size() > 0 ? q1[0] : 10'h3ff) !== m1(7'h55, 1'b1, 1'b1, 1'b1)) begin
      miscompares++; $display("FAIL parity_bad got %h want %h", q1.size() > 0 ? q1[0] : 10'h3ff, m1(7'h55, 1'b1, 1'b1, 1'b1));
    end
    vectors++;
    if ((q1.size() > 1 ? q1[1] : 10'h3ff) !== m1(7'h55, 1'b0, 1'b1, 1'b1)) begin
      miscompares++; $display("FAIL parity_good got %h want %h", q1.size() > 1 ? q1[1] : 10'h3ff, m1(7'h55, 1'b0, 1'b1, 1'b1));
    end
  endtask

  task automatic test_frame_break();
    int b, c;
    q0.delete(); rdy0 = 1'b1;
    send(0, {7'd0, 1'b0, 8'h81}, 9);
    idle(2 * BIT);
    vectors++;
    if ((q0.size() > 0 ? q0[0] : 10'h3ff) !== m0(8'h81, 1'b0) || q0.size() !== 1) begin
      miscompares++; $display("FAIL frame_err_word got %h (n=%0d) want %h", q0.size() > 0 ? q0[0] : 10'h3ff, q0.size(), m0(8'h81, 1'b0));
    end
    b = brk0; c = vcyc0;
    step(); rx0 = 1'b0;
    idle(12 * BIT);
    rx0 = 1'b1;
    idle(2 * BIT);
    vectors++;
    if (brk0 - b !== 1 || vcyc0 !== c) begin
      miscompares++; $display("FAIL break got pulses=%0d valids=%0d want pulses=1 valids=0", brk0 - b, vcyc0 - c);
    end
    q0.delete();
    send(0, {7'd0, 1'b1, 8'h12}, 9);
    idle(2 * BIT);
    vectors++;
    if ((q0.size() > 0 ? q0[0] : 10'h3ff) !== m0(8'h12, 1'b1) || q0.size() !== 1) begin
      miscompares++; $display("FAIL after_break_word got %h (n=%0d) want %h", q0.size() > 0 ? q0[0] : 10'h3ff, q0.size(), m0(8'h12, 1'b1));
    end
  endtask

  task automatic test_overrun();
    q0.delete(); rdy0 = 1'b0;
    send(0, {7'd0, 1'b1, 8'h11}, 9);
    idle(BIT);
    send(0, {7'd0, 1'b1, 8'h22}, 9);
    idle(2 * BIT);
    vectors++;
    if ({v0, ov0, d0} !== {1'b1, 1'b1, 8'h11}) begin
      miscompares++; $display("FAIL overrun_hold got v=%b ov=%b d=%h want v=1 ov=1 d=11", v0, ov0, d0);
    end
    rdy0 = 1'b1; step(); rdy0 = 1'b0;
    vectors++;
    if ({v0, ov0} !== 2'b01) begin
      miscompares++; $display("FAIL overrun_accept got v=%b ov=%b want v=0 ov=1", v0, ov0);
    end
    vectors++;
    if ((q0.size() > 0 ? q0[0] : 10'h3ff) !== m0(8'h11, 1'b1) || q0.size() !== 1) begin
      miscompares++; $display("FAIL overrun_word got %h (n=%0d) want %h", q0.size() > 0 ? q0[0] : 10'h3ff, q0.size(), m0(8'h11, 1'b1));
    end
    sr0 = 1'b1; step(); sr0 = 1'b0;
    vectors++;
    if ({v0, ov0} !== 2'b00) begin
      miscompares++; $display("FAIL soft_reset got v=%b ov=%b want 0 0", v0, ov0);
    end
  endtask

  task automatic test_rst_mid();
    int c;
    q0.delete(); rdy0 = 1'b1; c = vcyc0;
    fork
      send(0, {7'd0, 1'b1, 8'hF0}, 9);
      begin
        idle(4 * BIT);
        vectors++;
        if (by0 !== 1'b1) begin miscompares++; $display("FAIL rst_mid_busy got %b want 1", by0); end
        rst = 1'b1;
        idle(2 * BIT);
        rst = 1'b0;
      end
    join
    idle(2 * BIT);
    vectors++;
    if (vcyc0 !== c || by0 !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_silent got valids=%0d busy=%b want 0 0", vcyc0 - c, by0);
    end
    send(0, {7'd0, 1'b1, 8'h0F}, 9);
    idle(2 * BIT);
    vectors++;
    if ((q0.size() > 0 ? q0[0] : 10'h3ff) !== m0(8'h0F, 1'b1) || q0.size() !== 1) begin
      miscompares++; $display("FAIL rst_mid_next got %h (n=%0d) want %h", q0.size() > 0 ? q0[0] : 10'h3ff, q0.size(), m0(8'h0F, 1'b1));
    end
  endtask

  task automatic test_back_to_back();
    q0.delete(); rdy0 = 1'b0;
    send(0, {7'd0, 1'b1, 8'h33}, 9);
    idle(BIT);
    fork
      send(0, {7'd0, 1'b1, 8'hC4}, 9);
      begin
        repeat (773) step();
        rdy0 = 1'b1;
        step();
        rdy0 = 1'b0;
      end
    join
    idle(BIT);
    vectors++;
    if ({v0, ov0, d0} !== {1'b1, 1'b0, 8'hC4}) begin
      miscompares++; $display("FAIL b2b_hold got v=%b ov=%b d=%h want v=1 ov=0 d=c4", v0, ov0, d0);
    end
    vectors++;
    if ((q0.size() > 0 ? q0[0] : 10'h3ff) !== m0(8'h33, 1'b1) || q0.size() !== 1) begin
      miscompares++; $display("FAIL b2b_first got %h (n=%0d) want %h", q0.size() > 0 ? q0[0] : 10'h3ff, q0.size(), m0(8'h33, 1'b1));
    end
    rdy0 = 1'b1; step();
  endtask

  task automatic test_random();
    logic [9:0] e0[$], e1[$];
    int eb0 = 0, eb1 = 0, b0, b1;
    logic [7:0] w;
    logic [6:0] u;
    logic s, p, s1, s2;
    q0.delete(); q1.delete(); rdy0 = 1'b1; rdy1 = 1'b1; b0 = brk0; b1 = brk1;
    for (int k = 0; k < 6; k++) begin
      w = 8'($urandom); s = $urandom_range(0, 3) != 0;
      u = 7'($urandom); p = 1'($urandom); s1 = $urandom_range(0, 3) != 0; s2 = $urandom_range(0, 3) != 0;
      if (k == 5) begin w = 8'd0; s = 1'b0; u = 7'd0; p = 1'b0; s1 = 1'b0; end
      if (w == 8'd0 && !s) eb0++; else e0.push_back(m0(w, s));
      if (u == 7'd0 && !p && !s1) eb1++; else e1.push_back(m1(u, p, s1, s2));
      fork
        send(0, {7'd0, s, w}, 9);
        send(1, {5'd0, s2, s1, p, u}, 10);
      join
      idle(2 * BIT);
    end
    vectors++;
    if (q0.size() !== e0.size() || brk0 - b0 !== eb0) begin
      miscompares++; $display("FAIL rand0_count got n=%0d brk=%0d want n=%0d brk=%0d", q0.size(), brk0 - b0, e0.size(), eb0);
    end
    vectors++;
    if (q1.size() !== e1.size() || brk1 - b1 !== eb1) begin
      miscompares++; $display("FAIL rand1_count got n=%0d brk=%0d want n=%0d brk=%0d", q1.size(), brk1 - b1, e1.size(), eb1);
    end
    for (int k = 0; k < e0.size(); k++) begin
      vectors++;
      if ((k < q0.size() ? q0[k] : 10'h3ff) !== e0[k]) begin
        miscompares++; $display("FAIL rand0[%0d] got %h want %h", k, k < q0.size() ? q0[k] : 10'h3ff, e0[k]);
      end
    end
    for (int k = 0; k < e1.size(); k++) begin
      vectors++;
      if ((k < q1.size() ? q1[k] : 10'h3ff) !== e1[k]) begin
        miscompares++; $display("FAIL rand1[%0d] got %h want %h", k, k < q1.size() ? q1[k] : 10'h3ff, e1[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_frame_break();
    test_overrun();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver used on the WIC serial links. It oversamples the line, majority-votes each bit and supports configurable data width, parity and stop bits. It reports parity, framing, overrun and break conditions, and presents received words on a valid/ready handshake so a FIFO or CPU interface can apply backpressure.

Parameters:
CLOCK_FREQ, 38400000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; even, 8..32
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rx  in  1  serial line, asynchronous to clk, idle high
soft_reset  in  1  synchronous clear: FSM to IDLE, valid/overrun/errors to 0
data  out  DATA_BITS  received word, LSB = first bit on line
valid  out  1  data and error flags are valid
ready  in  1  consumer accepts the word when valid && ready
parity_err  out  1  parity mismatch for the presented word
frame_err  out  1  a stop bit sampled 0 for the presented word
overrun  out  1  sticky; a frame completed while valid && !ready
break_det  out  1  one-cycle pulse when a break is detected
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst or soft_reset): all outputs are 0, FSM is IDLE, synchroniser flops are 1, tick counters are 0.
- rx passes through a 2-flop synchroniser. All references to rx below mean the synchronised value.
- Tick divider: DIV = (CLOCK_FREQ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE), i.e. rounded. Defaults give DIV = 250 and 4000 clk per bit.
- The divider and the per-bit tick index (0..OVERSAMPLE-1) are cleared on the IDLE falling-edge detect, which aligns sampling to the start edge.
- Each bit's value is the majority of the samples at ticks OS/2-1, OS/2 and OS/2+1. The value is decided at tick OS/2+1. The bit ends after tick OS-1.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
- IDLE: rx = 0 -> START.
- START: a voted 1 is a false start and returns to IDLE with no report. Otherwise -> DATA at the bit end.
- DATA: shift DATA_BITS bits LSB first. After the last bit -> PAR if PARITY != 0, else STOP.
- PAR: compute parity over the data bits. Odd mode: XOR of data and parity bit must be 1. Even mode: it must be 0.
- STOP: STOP_BITS bits. Any stop bit voted 0 sets frame_err for the frame. The frame completes at the vote of the last stop bit; the FSM does not wait for the bit end. It then returns to IDLE, or goes to WAIT_HIGH on a break.
- Break: all data bits 0, the parity bit 0 if present, and the first stop bit 0. The frame is not delivered. break_det pulses 1 clk at the completion point. The FSM goes to WAIT_HIGH and stays there until rx = 1, then enters IDLE.
- Completion latency: valid rises 1 clk after the final stop-bit vote tick. data, parity_err and frame_err update in the same cycle.
- Handshake: data and flags hold stable while valid && !ready. On valid && ready, valid falls next clk unless a new frame completes in that same cycle. In that case valid stays 1 and the new word is loaded, which counts as accepted, not overrun.
- Overrun: a frame completes while valid && !ready. The new frame is discarded, the held word is kept, and overrun is set. overrun clears only on rst or soft_reset.
- rx toggling while in WAIT_HIGH or in the middle of a bit has no effect beyond the voting.
- Reset mid-frame: an asynchronous rst returns to IDLE at once. No partial word is ever presented.
- soft_reset has priority over a completion in the same cycle.

Test Plan:
- Defaults, send 0xA5 8N1 at 4000 clk per bit, ready = 1 -> valid pulses 1 clk with data = 0xA5 and all flags 0, about 9.5 bit times (~38000 clk) after the start edge.
- 1500-clk low glitch on idle rx -> no valid, busy returns to 0, and the next frame 0x3C is received correctly.
- DATA_BITS = 7, PARITY = 2, STOP_BITS = 2; send 0x55 with parity bit 1 -> valid, data = 0x55, parity_err = 1. Resend with parity 0 -> parity_err = 0.
- Defaults, send 0x81 with stop bit 0 -> valid, data = 0x81, frame_err = 1. Then hold rx low for 12 bit times -> break_det pulses once, no valid. rx returns high -> the next frame 0x12 is received.
- Hold ready = 0 and send 0x11 then 0x22 -> data stays 0x11, overrun = 1. Pulse ready -> valid falls. soft_reset -> overrun = 0.
- Assert rst mid DATA state of frame 0xF0 and release it -> no valid. A subsequent 0x0F arrives intact. Also cover ready = 1 in the same cycle as a new completion -> valid stays high, data = the new word, overrun = 0.
